// File: rtl/mesh_term_arbiter_if.sv
// Handshake bundle between the per-source input FIFOs, the arbiter and one
// mesh terminal input port. The master side is the arbiter itself.
interface mesh_term_arbiter_if #(
    parameter int N_SRC   = 4,
    parameter int pckg_sz = 40
);
    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]         src_pndng;
    logic [N_SRC*pckg_sz-1:0] src_data;
    logic [N_SRC-1:0]         src_pop;
    logic                     pndng_i_in;
    logic [pckg_sz-1:0]       data_out_i_in;
    logic                     popin;
    logic [GW-1:0]            grant_id;
    logic                     dest_err;
    logic [15:0]              fwd_cnt;
    logic [15:0]              err_cnt;

    modport master (
        input  src_pndng, src_data, popin,
        output src_pop, pndng_i_in, data_out_i_in, grant_id, dest_err, fwd_cnt, err_cnt
    );

    modport slave (
        output src_pndng, src_data, popin,
        input  src_pop, pndng_i_in, data_out_i_in, grant_id, dest_err, fwd_cnt, err_cnt
    );
endinterface

// File: rtl/mesh_term_arbiter.sv
// Round-robin arbiter sharing one mesh terminal input between N_SRC local
// packet sources. Packets aimed at edge terminals are offered to the mesh
// until consumed; anything else is popped, dropped and counted.
module mesh_term_arbiter #(
    parameter int N_SRC   = 4,
    parameter int ROWS    = 4,
    parameter int COLUMS  = 4,
    parameter int pckg_sz = 40
) (
    input logic clk,
    input logic reset,
    mesh_term_arbiter_if.master bus
);
    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, OFFER, DROP} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        lastGrant_q, lastGrant_d;
    logic [N_SRC-1:0]     srcPop_q, srcPop_d;
    logic                 pndng_q, pndng_d;
    logic [pckg_sz-1:0]   data_q, data_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic                 destErr_q, destErr_d;
    logic [15:0]          fwdCnt_q, fwdCnt_d;
    logic [15:0]          errCnt_q, errCnt_d;

    int                   cand;
    logic [GW-1:0]        candIdx;
    logic                 found;
    logic [GW-1:0]        winner;
    logic [pckg_sz-1:0]   rawPkt;
    logic [pckg_sz-1:0]   capPkt;
    int                   rowV;
    int                   colV;
    logic                 legal;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand    = (int'(lastGrant_q) + k) % N_SRC;
            candIdx = cand[GW-1:0];
            if (!found && bus.src_pndng[candIdx]) begin
                found  = 1'b1;
                winner = candIdx;
            end
        end
    end

    // Select the winner's head packet, clear its hop field and classify the destination.
    always_comb begin
        rawPkt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (winner == GW'(i)) begin
                rawPkt = bus.src_data[i*pckg_sz +: pckg_sz];
            end
        end
        capPkt = {8'h00, rawPkt[pckg_sz-9:0]};
        rowV   = {28'd0, rawPkt[pckg_sz-9 -: 4]};
        colV   = {28'd0, rawPkt[pckg_sz-13 -: 4]};
        legal  = ((rowV >= 1) && (rowV <= ROWS) && ((colV == 0) || (colV == COLUMS + 1))) ||
                 ((colV >= 1) && (colV <= COLUMS) && ((rowV == 0) || (rowV == ROWS + 1)));
    end

    // Next-state and output logic; pulses default low, everything else holds.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        srcPop_d    = '0;
        pndng_d     = pndng_q;
        data_d      = data_q;
        grant_d     = grant_q;
        destErr_d   = 1'b0;
        fwdCnt_d    = fwdCnt_q;
        errCnt_d    = errCnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    srcPop_d[winner] = 1'b1;
                    grant_d          = winner;
                    lastGrant_d      = winner;
                    if (legal) begin
                        data_d  = capPkt;
                        pndng_d = 1'b1;
                        state_d = OFFER;
                    end else begin
                        destErr_d = 1'b1;
                        errCnt_d  = errCnt_q + 16'd1;
                        state_d   = DROP;
                    end
                end
            end
            OFFER: begin
                if (bus.popin) begin
                    pndng_d  = 1'b0;
                    fwdCnt_d = fwdCnt_q + 16'd1;
                    state_d  = IDLE;
                end
            end
            DROP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset makes source 0 the first priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lastGrant_q <= GW'(N_SRC - 1);
            srcPop_q    <= '0;
            pndng_q     <= 1'b0;
            data_q      <= '0;
            grant_q     <= '0;
            destErr_q   <= 1'b0;
            fwdCnt_q    <= '0;
            errCnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            srcPop_q    <= srcPop_d;
            pndng_q     <= pndng_d;
            data_q      <= data_d;
            grant_q     <= grant_d;
            destErr_q   <= destErr_d;
            fwdCnt_q    <= fwdCnt_d;
            errCnt_q    <= errCnt_d;
        end
    end

    assign bus.src_pop       = srcPop_q;
    assign bus.pndng_i_in    = pndng_q;
    assign bus.data_out_i_in = data_q;
    assign bus.grant_id      = grant_q;
    assign bus.dest_err      = destErr_q;
    assign bus.fwd_cnt       = fwdCnt_q;
    assign bus.err_cnt       = errCnt_q;
endmodule
